// File: rtl/noise_est_block_sequencer_if.sv
// Pixel stream handshake between a pixel source and noise_est_block_sequencer.
interface noise_est_block_sequencer_if #(
  parameter int unsigned DATA_WIDTH = 8
) ();
  logic                  pix_valid;
  logic [DATA_WIDTH-1:0] pix_data;
  logic                  pix_ready;

  modport master (output pix_valid, output pix_data, input pix_ready);
  modport slave  (input pix_valid, input pix_data, output pix_ready);
endinterface

// File: rtl/noise_est_block_sequencer.sv
// Buffers a pixel stream and replays it as gap-free TOTAL_SAMPLES bursts into noise_estimation.
// Optional WAIT_MEAN/WAIT_NOISE watchdog is enabled by defining NOISE_SEQ_WATCHDOG_EN.
module noise_est_block_sequencer #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned TOTAL_SAMPLES = 8,
  parameter int unsigned FIFO_DEPTH    = 16,
  parameter int unsigned GAP_CYCLES    = 3,
  parameter int unsigned WDOG_CYCLES   = 1024
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      frame_start,
  input  logic [31:0]               blocks_per_frame,
  noise_est_block_sequencer_if.slave pix,
  output logic                      ne_start_of_frame,
  output logic                      ne_end_of_frame,
  output logic                      ne_start_data,
  output logic [DATA_WIDTH-1:0]     ne_data_in,
  input  logic                      ne_mean_ready,
  input  logic [2*DATA_WIDTH-1:0]   ne_noise,
  input  logic                      ne_noise_ready,
  output logic [2*DATA_WIDTH-1:0]   noise_out,
  output logic                      noise_valid,
  output logic                      busy,
  output logic [31:0]               block_idx,
  output logic                      proto_err
);

  localparam int unsigned AddrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = AddrW + 1;
  localparam int unsigned BeatW = $clog2(TOTAL_SAMPLES + 1);
  localparam int unsigned GapW  = $clog2(GAP_CYCLES + 2);

  if (TOTAL_SAMPLES == 0 || FIFO_DEPTH < TOTAL_SAMPLES ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo
    $error("FIFO_DEPTH must be a power of two and >= TOTAL_SAMPLES >= 1");
  end
  if (WDOG_CYCLES == 0) begin : g_bad_wdog
    $error("WDOG_CYCLES must be non-zero");
  end

  typedef enum logic [2:0] {
    StIdle, StWaitFill, StBurst, StWaitMean, StGap, StWaitNoise
  } state_e;

  state_e                  state_q, state_d;
  logic [31:0]             bpf_q, bpf_d;
  logic [31:0]             blk_q, blk_d;
  logic [BeatW-1:0]        beat_q, beat_d;
  logic [GapW-1:0]         gap_q, gap_d;

  logic [DATA_WIDTH-1:0]   mem [FIFO_DEPTH];
  logic [AddrW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic                    push, pop, flush;

  logic                    pix_ready_q, busy_q, perr_q, perr_d, capture;
  logic                    sd_q, sd_d, sof_q, sof_d, eof_q, eof_d, noise_valid_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [2*DATA_WIDTH-1:0] noise_q;

`ifdef NOISE_SEQ_WATCHDOG_EN
  localparam int unsigned WdogW = $clog2(WDOG_CYCLES + 1);
  logic [WdogW-1:0] wdog_q, wdog_d;
  logic             in_wait, wdog_hit;
  assign in_wait  = (state_q == StWaitMean) || (state_q == StWaitNoise);
  assign wdog_hit = in_wait && (wdog_q == WdogW'(WDOG_CYCLES - 1));
`endif

  assign push = pix.pix_valid && pix_ready_q;

  always_comb begin
    state_d = state_q;
    bpf_d   = bpf_q;
    blk_d   = blk_q;
    beat_d  = beat_q;
    gap_d   = gap_q;
    pop     = 1'b0;
    flush   = 1'b0;
    capture = 1'b0;
    perr_d  = 1'b0;
    sd_d    = 1'b0;
    sof_d   = 1'b0;
    eof_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (frame_start) begin
          if (blocks_per_frame != 32'd0) begin
            bpf_d   = blocks_per_frame;
            blk_d   = 32'd0;
            state_d = StWaitFill;
          end else begin
            perr_d = 1'b1;
          end
        end
      end
      StWaitFill: begin
        if (cnt_q >= CntW'(TOTAL_SAMPLES)) begin
          beat_d  = '0;
          state_d = StBurst;
        end
      end
      StBurst: begin
        pop   = 1'b1;
        sd_d  = (beat_q == '0);
        sof_d = (beat_q == '0) && (blk_q == 32'd0);
        eof_d = (beat_q == '0) && (blk_q == bpf_q - 32'd1);
        if (beat_q == BeatW'(TOTAL_SAMPLES - 1)) begin
          if (blk_q == bpf_q - 32'd1) begin
            state_d = StWaitNoise;
          end else begin
            blk_d   = blk_q + 32'd1;
            state_d = StWaitMean;
          end
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      StWaitMean: begin
        if (ne_mean_ready) begin
          gap_d   = '0;
          state_d = (GAP_CYCLES == 0) ? StWaitFill : StGap;
        end
      end
      StGap: begin
        if (gap_q == GapW'(GAP_CYCLES - 1)) begin
          state_d = StWaitFill;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      StWaitNoise: begin
        if (ne_noise_ready) begin
          capture = 1'b1;
          flush   = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (frame_start && (state_q != StIdle)) begin
      perr_d = 1'b1;
    end

`ifdef NOISE_SEQ_WATCHDOG_EN
    // A handshake arriving on the expiry cycle still wins over the timeout.
    if (wdog_hit && (state_d == state_q)) begin
      flush   = 1'b1;
      perr_d  = 1'b1;
      state_d = StIdle;
    end
`endif
  end

`ifdef NOISE_SEQ_WATCHDOG_EN
  always_comb begin
    wdog_d = '0;
    if (in_wait && (state_d == state_q)) begin
      wdog_d = wdog_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_d;
    end
  end
`endif

  always_comb begin
    cnt_d    = cnt_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      cnt_d    = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr_q] <= pix.pix_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      bpf_q         <= 32'd0;
      blk_q         <= 32'd0;
      beat_q        <= '0;
      gap_q         <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      cnt_q         <= '0;
      pix_ready_q   <= 1'b0;
      busy_q        <= 1'b0;
      perr_q        <= 1'b0;
      sd_q          <= 1'b0;
      sof_q         <= 1'b0;
      eof_q         <= 1'b0;
      data_q        <= '0;
      noise_q       <= '0;
      noise_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      bpf_q         <= bpf_d;
      blk_q         <= blk_d;
      beat_q        <= beat_d;
      gap_q         <= gap_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      cnt_q         <= cnt_d;
      // Registered from next-state so it equals (state != IDLE) && !full each cycle.
      pix_ready_q   <= (state_d != StIdle) && (cnt_d != CntW'(FIFO_DEPTH));
      busy_q        <= (state_d != StIdle);
      perr_q        <= perr_d;
      sd_q          <= sd_d;
      sof_q         <= sof_d;
      eof_q         <= eof_d;
      noise_valid_q <= capture;
      if (pop)     data_q  <= mem[rd_ptr_q];
      if (capture) noise_q <= ne_noise;
    end
  end

  assign pix.pix_ready       = pix_ready_q;
  assign busy                = busy_q;
  assign proto_err           = perr_q;
  assign block_idx           = blk_q;
  assign ne_start_data       = sd_q;
  assign ne_start_of_frame   = sof_q;
  assign ne_end_of_frame     = eof_q;
  assign ne_data_in          = data_q;
  assign noise_out           = noise_q;
  assign noise_valid         = noise_valid_q;

endmodule

// File: tb/tb_noise_est_block_sequencer.sv
// Scoreboard bench for noise_est_block_sequencer: pixels are queued as expected burst beats on
// acceptance and compared as they leave the sequencer, with mean_ready/noise_ready stubs.
module tb_noise_est_block_sequencer;
  localparam int unsigned DW   = 8;
  localparam int unsigned TS   = 8;
  localparam int unsigned FD   = 16;
  localparam int unsigned GAP  = 3;
  localparam int unsigned WDOG = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic              frame_start;
  logic [31:0]       bpf;
  logic              ne_sof, ne_eof, ne_sd;
  logic [DW-1:0]     ne_data;
  logic              mean_stub, mean_spur, ne_mean_ready, ne_noise_ready;
  logic [2*DW-1:0]   ne_noise, noise_out;
  logic              noise_valid, busy, proto_err;
  logic [31:0]       block_idx;

  assign ne_mean_ready = mean_stub | mean_spur;

  noise_est_block_sequencer_if #(.DATA_WIDTH(DW)) pix_if ();

  noise_est_block_sequencer #(
    .DATA_WIDTH(DW), .TOTAL_SAMPLES(TS), .FIFO_DEPTH(FD), .GAP_CYCLES(GAP), .WDOG_CYCLES(WDOG)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .blocks_per_frame(bpf), .pix(pix_if),
    .ne_start_of_frame(ne_sof), .ne_end_of_frame(ne_eof), .ne_start_data(ne_sd),
    .ne_data_in(ne_data), .ne_mean_ready(ne_mean_ready), .ne_noise(ne_noise),
    .ne_noise_ready(ne_noise_ready), .noise_out(noise_out), .noise_valid(noise_valid),
    .busy(busy), .block_idx(block_idx), .proto_err(proto_err)
  );

  typedef struct packed {
    logic          sd;
    logic          sof;
    logic          eof;
    logic [DW-1:0] data;
  } beat_t;

  beat_t pix_q[$];
  beat_t exp_q[$];

  int n_tests = 0, n_fail = 0;
  int cyc = 0, bursts = 0, beats_seen = 0, noise_cnt = 0, perr_cnt = 0, perr_cyc = 0;
  int mean_cnt = 0, last_mean_cyc = -100, burst_end_cyc = 0;
  bit auto_mean = 1'b1;
  logic [2*DW-1:0] noise_val = 16'h1234;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] nom_pix(input int i);
    case (i)
      0:       return 8'd203;
      1:       return 8'd222;
      2:       return 8'd235;
      56:      return 8'd18;
      63:      return 8'd245;
      default: return 8'((i * 53 + 7) % 251);
    endcase
  endfunction

  task automatic load_frame(input int nb, input int seed);
    beat_t b;
    for (int i = 0; i < nb * int'(TS); i++) begin
      b.data = (seed == 0) ? nom_pix(i) : 8'(i * 29 + seed);
      b.sd   = (i % int'(TS)) == 0;
      b.sof  = (i == 0);
      b.eof  = b.sd && ((i / int'(TS)) == nb - 1);
      pix_q.push_back(b);
    end
  endtask

  task automatic pulse_start(input logic [31:0] n);
    @(negedge clk);
    frame_start = 1'b1;
    bpf         = n;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic wait_bursts(input int target, input string tag);
    int t = 0;
    while (bursts < target && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_burst_wait"}, 32'(bursts >= target), 32'd1);
  endtask

  task automatic wait_noise(input string tag);
    int n0 = noise_cnt;
    int t  = 0;
    while (noise_cnt == n0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    repeat (6) @(negedge clk);
    check({tag, "_noise_pulses"}, noise_cnt - n0, 32'd1);
    check({tag, "_busy_low"}, 32'(busy), 32'd0);
    check({tag, "_sb_drained"}, exp_q.size(), 32'd0);
  endtask

  // Pixel source: valid whenever something is queued; beats accepted become expectations.
  initial begin
    pix_if.pix_valid = 1'b0;
    pix_if.pix_data  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n || pix_q.size() == 0) begin
        pix_if.pix_valid = 1'b0;
      end else begin
        pix_if.pix_valid = 1'b1;
        pix_if.pix_data  = pix_q[0].data;
        if (pix_if.pix_ready) exp_q.push_back(pix_q.pop_front());
      end
    end
  end

  always @(posedge clk) begin
    if (ne_mean_ready) begin
      mean_cnt      <= mean_cnt + 1;
      last_mean_cyc <= cyc;
    end
  end

  // Output monitor plus noise_estimation stubs.
  initial begin : mon
    int    beats_left;
    int    mean_timer;
    int    noise_timer;
    bit    cur_last;
    beat_t e;
    beats_left = 0; mean_timer = 0; noise_timer = 0; cur_last = 1'b0;
    mean_stub = 1'b0; ne_noise_ready = 1'b0; ne_noise = '0;
    forever begin
      @(negedge clk);
      cyc++;
      mean_stub      = 1'b0;
      ne_noise_ready = 1'b0;
      ne_noise       = noise_val;
      if (!rst_n) begin
        beats_left = 0; mean_timer = 0; noise_timer = 0;
        exp_q.delete();
      end else begin
        if (mean_timer > 0) begin
          mean_timer--;
          if (mean_timer == 0) mean_stub = 1'b1;
        end
        if (noise_timer > 0) begin
          noise_timer--;
          if (noise_timer == 0) ne_noise_ready = 1'b1;
        end
        if (proto_err) begin
          perr_cnt++;
          perr_cyc = cyc;
        end
        if (noise_valid) noise_cnt++;
        if (beats_left == 0 && !ne_sd && (ne_sof || ne_eof)) check("stray_strobe", 32'd1, 32'd0);
        if (ne_sd) begin
          check("burst_gap_free", beats_left, 32'd0);
          beats_left = TS;
        end
        if (beats_left > 0) begin
          if (exp_q.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("data", 32'(ne_data), 32'(e.data));
            check("strobes", 32'({ne_sd, ne_sof, ne_eof}), 32'({e.sd, e.sof, e.eof}));
            if (beats_left == int'(TS)) begin
              cur_last = e.eof;
              if (!e.sof) begin
                check("mean_before_burst", 32'(last_mean_cyc > burst_end_cyc), 32'd1);
                check("gap_idle", 32'((cyc - last_mean_cyc - 1) >= int'(GAP)), 32'd1);
              end
            end
          end
          beats_seen++;
          beats_left--;
          if (beats_left == 0) begin
            bursts++;
            burst_end_cyc = cyc;
            if (cur_last) noise_timer = 4;
            else if (auto_mean) mean_timer = 5;
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got no finish expected finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int b0, m0, t;
    frame_start = 1'b0; bpf = '0; mean_spur = 1'b0; rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pix_ready", 32'(pix_if.pix_ready), 32'd0);
    check("rst_proto_err", 32'(proto_err), 32'd0);
    check("rst_noise_valid", 32'(noise_valid), 32'd0);
    check("rst_noise_out", 32'(noise_out), 32'd0);
    check("rst_block_idx", block_idx, 32'd0);
    check("rst_strobes", 32'({ne_sd, ne_sof, ne_eof}), 32'd0);
    check("rst_data", 32'(ne_data), 32'd0);
    @(posedge clk); #2 rst_n = 1'b1;

    // Nominal 8-block frame.
    b0 = bursts; m0 = perr_cnt;
    load_frame(8, 0);
    pulse_start(8);
    wait_noise("nominal");
    check("nom_bursts", bursts - b0, 32'd8);
    check("nom_noise_out", 32'(noise_out), 32'h1234);
    check("nom_no_perr", perr_cnt - m0, 32'd0);

    // Mid-frame frame_start and a spurious mean_ready inside a burst.
    b0 = bursts; noise_val = 16'h0a5c;
    load_frame(2, 17);
    pulse_start(2);
    pulse_start(5);
    check("mid_perr", 32'(proto_err), 32'd1);
    check("mid_busy", 32'(busy), 32'd1);
    t = 0;
    while (!ne_sd && t < 200) begin @(negedge clk); t++; end
    check("mid_burst_seen", 32'(ne_sd), 32'd1);
    mean_spur = 1'b1;
    @(negedge clk);
    mean_spur = 1'b0;
    wait_noise("midframe");
    check("mid_bursts", bursts - b0, 32'd2);
    check("mid_noise_out", 32'(noise_out), 32'h0a5c);

    // Back-pressure: FIFO fills while mean_ready is withheld.
    auto_mean = 1'b0; b0 = bursts; noise_val = 16'h1234;
    load_frame(4, 91);
    pulse_start(4);
    wait_bursts(b0 + 1, "bp");
    repeat (20) @(negedge clk);
    check("bp_ready_low", 32'(pix_if.pix_ready), 32'd0);
    check("bp_valid_high", 32'(pix_if.pix_valid), 32'd1);
    check("bp_block_idx", block_idx, 32'd1);
    auto_mean = 1'b1;
    mean_spur = 1'b1;
    @(negedge clk);
    mean_spur = 1'b0;
    t = 0;
    while (!pix_if.pix_ready && t < 20) begin @(negedge clk); t++; end
    check("bp_ready_rise", 32'(pix_if.pix_ready), 32'd1);
    wait_noise("backpressure");
    check("bp_bursts", bursts - b0, 32'd4);

    // Single-block frame goes straight to WAIT_NOISE.
    m0 = mean_cnt; noise_val = 16'hbeef;
    load_frame(1, 200);
    pulse_start(1);
    wait_noise("single");
    check("single_no_mean", mean_cnt - m0, 32'd0);
    check("single_noise_out", 32'(noise_out), 32'hbeef);

    // Zero-block frame request.
    pulse_start(0);
    check("zero_perr", 32'(proto_err), 32'd1);
    check("zero_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("zero_perr_pulse", 32'(proto_err), 32'd0);

    // Reset in the middle of a burst.
    load_frame(2, 5);
    pulse_start(2);
    b0 = beats_seen; t = 0;
    while (beats_seen - b0 < 3 && t < 200) begin @(negedge clk); t++; end
    check("rst_mid_beats", beats_seen - b0, 32'd3);
    @(posedge clk); #2 rst_n = 1'b0;
    pix_q.delete();
    #1;
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_pix_ready", 32'(pix_if.pix_ready), 32'd0);
    check("rstmid_strobes", 32'({ne_sd, ne_sof, ne_eof}), 32'd0);
    check("rstmid_data", 32'(ne_data), 32'd0);
    check("rstmid_noise_out", 32'(noise_out), 32'd0);
    repeat (2) @(negedge clk);
    @(posedge clk); #2 rst_n = 1'b1;
    noise_val = 16'h4321;
    load_frame(2, 77);
    pulse_start(2);
    wait_noise("post_rst");
    check("post_rst_noise_out", 32'(noise_out), 32'h4321);

`ifdef NOISE_SEQ_WATCHDOG_EN
    // Watchdog: mean_ready never arrives.
    auto_mean = 1'b0; b0 = bursts; m0 = noise_cnt;
    load_frame(2, 33);
    pulse_start(2);
    wait_bursts(b0 + 1, "wdog");
    t = perr_cnt;
    while (perr_cnt == t && (cyc - burst_end_cyc) < 100) @(negedge clk);
    check("wdog_latency", perr_cyc - burst_end_cyc, WDOG);
    check("wdog_busy", 32'(busy), 32'd0);
    repeat (4) @(negedge clk);
    check("wdog_no_noise", noise_cnt - m0, 32'd0);
    exp_q.delete();
    auto_mean = 1'b1;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/noise_est_block_sequencer.md
Name: noise_est_block_sequencer

Overview:
- Controller that sequences the noise_estimation datapath for one frame at a time.
- Accepts a pixel stream through a valid/ready handshake and buffers it in an internal FIFO.
- Replays each block of TOTAL_SAMPLES pixels as a gap-free burst, with the start_data, start_of_frame and end_of_frame strobes that noise_estimation requires.
- Throttles bursts on mean_ready, then captures the final estimated_noise result.

Parameters:
- DATA_WIDTH, 8: pixel width.
- TOTAL_SAMPLES, 8: pixels per block (burst length).
- FIFO_DEPTH, 16: input buffer depth; must be >= TOTAL_SAMPLES; power of two.
- GAP_CYCLES, 3: idle cycles after mean_ready before the next burst may start.
- WDOG_CYCLES, 1024: watchdog limit (used only with the optional feature).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- frame_start  in  1  one-cycle pulse; starts a frame
- blocks_per_frame  in  32  block count, sampled on an accepted frame_start
- pix_valid  in  1  input pixel valid
- pix_data  in  DATA_WIDTH  input pixel
- pix_ready  out  1  FIFO can accept a pixel
- ne_start_of_frame  out  1  to noise_estimation.start_of_frame
- ne_end_of_frame  out  1  to noise_estimation.end_of_frame
- ne_start_data  out  1  to noise_estimation.start_data
- ne_data_in  out  DATA_WIDTH  to noise_estimation.data_in
- ne_mean_ready  in  1  from noise_estimation.mean_ready
- ne_noise  in  2*DATA_WIDTH  from noise_estimation.estimated_noise
- ne_noise_ready  in  1  from noise_estimation.estimated_noise_ready
- noise_out  out  2*DATA_WIDTH  captured frame noise estimate
- noise_valid  out  1  one-cycle pulse with noise_out
- busy  out  1  state != IDLE
- block_idx  out  32  index of the current block
- proto_err  out  1  one-cycle pulse on a protocol violation

Behaviour:
- Reset: all outputs are 0, the FIFO is empty and the state is IDLE.
- All outputs are registered.
- Input handshake:
  - pix_ready = (state != IDLE) && !fifo_full.
  - A push occurs when pix_valid && pix_ready.
  - Push and pop in the same cycle are legal; the count is unchanged and no data is lost at full.
- State machine:
  - IDLE: on frame_start with blocks_per_frame != 0, latch bpf, clear block_idx, go to WAIT_FILL. If blocks_per_frame == 0, stay in IDLE and pulse proto_err.
  - WAIT_FILL: when fifo_count >= TOTAL_SAMPLES, go to BURST.
  - BURST: pop one pixel per cycle for exactly TOTAL_SAMPLES consecutive cycles. ne_data_in carries each popped pixel in the cycle after its pop, so the burst output is contiguous.
    - First burst cycle: ne_start_data = 1.
    - ne_start_of_frame = 1 if block_idx == 0.
    - ne_end_of_frame = 1 if block_idx == bpf-1.
    - bpf == 1 asserts both in the same cycle.
    - All three strobes are 0 on every other cycle.
    - After the last pixel: if block_idx == bpf-1, go to WAIT_NOISE; otherwise increment block_idx and go to WAIT_MEAN.
  - WAIT_MEAN: on ne_mean_ready, go to GAP, or directly to WAIT_FILL when GAP_CYCLES == 0.
  - GAP: count GAP_CYCLES cycles, then go to WAIT_FILL. The FIFO keeps filling during the gap.
  - WAIT_NOISE: on ne_noise_ready, register ne_noise into noise_out and pulse noise_valid for one cycle. Flush the FIFO and go to IDLE.
- Latency: the first ne_data_in sample appears 2 cycles after the cycle in which fifo_count first reaches TOTAL_SAMPLES in WAIT_FILL.
- noise_out holds its value until the next capture or reset.
- frame_start while busy: ignored, proto_err pulses, and the frame in progress continues.
- ne_mean_ready outside WAIT_MEAN and ne_noise_ready outside WAIT_NOISE are ignored.
- Reset mid-frame: immediate return to reset values; the FIFO contents are lost.
- block_idx wraps nowhere; bpf bounds it.

Optional Feature:
- Macro: NOISE_SEQ_WATCHDOG_EN.
- Defined:
  - A counter runs while in WAIT_MEAN or WAIT_NOISE and clears on every state change.
  - On reaching WDOG_CYCLES: pulse proto_err, flush the FIFO, go to IDLE; noise_valid is not asserted.
- Undefined: no counter logic is present, and those states wait indefinitely.

Test Plan:
- Nominal frame (TOTAL_SAMPLES=8, bpf=8): stream the 64-pixel vector 203,222,235,...,245 with pix_valid held high. Stub mean_ready 5 cycles after each burst; stub noise_ready with ne_noise=16'h1234.
  - Expect 8 bursts of 8 contiguous samples, in input order.
  - ne_start_of_frame only on sample 203; ne_end_of_frame only on the first sample of block 7 (value 18).
  - ≥3 idle cycles between mean_ready and the next burst.
  - noise_out=16'h1234 with a single noise_valid pulse; busy then drops.
- Back-pressure: with the FIFO full (16 entries) and the sequencer in WAIT_MEAN, pix_ready=0. After mean_ready, the burst starts, pix_ready rises, and no pixel is dropped or duplicated.
- Single-block frame (bpf=1): the first burst cycle has start_data, start_of_frame and end_of_frame all 1. The FSM then goes straight to WAIT_NOISE without waiting for mean_ready.
- Protocol errors:
  - frame_start with bpf=0 gives proto_err=1 and busy stays 0.
  - frame_start mid-frame gives proto_err=1 and the burst sequence is unaffected.
  - A spurious ne_mean_ready during BURST has no effect.
- Reset mid-burst (after 3 of 8 samples): all outputs return to 0 immediately. A new frame then replays from block 0 with ne_start_of_frame on its first sample.
- With NOISE_SEQ_WATCHDOG_EN and WDOG_CYCLES=32, never assert mean_ready: proto_err pulses 32 cycles after entering WAIT_MEAN, busy falls, and noise_valid stays 0.
